// File: rtl/des_key_scheduler.sv
// DES key schedule generator: PC-1 on start, per-round C/D rotation, PC-2 subkey
// presented one round at a time under a valid/ready handshake, encrypt or decrypt order.
module des_key_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key_in,
    input  logic        abort,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    output logic [3:0]  round,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Tables use FIPS 1-based bit numbering; bit 1 is the MSB of the source vector.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_TAB[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_TAB[i]];
        return r;
    endfunction

    // Rotation amount for 0-based round index r; decrypt round 0 uses PC-1 unrotated.
    function automatic logic [1:0] shift_amt(input logic [3:0] r, input logic dec);
        if (dec && r == 4'd0)
            return 2'd0;
        else if (r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15)
            return 2'd1;
        else
            return 2'd2;
    endfunction

    function automatic logic [27:0] rot(input logic [27:0] v, input logic dec, input logic [1:0] amt);
        logic [27:0] r;
        r = v;
        case ({dec, amt})
            3'b001:  r = {v[26:0], v[27]};
            3'b010:  r = {v[25:0], v[27:26]};
            3'b101:  r = {v[0], v[27:1]};
            3'b110:  r = {v[1:0], v[27:2]};
            default: r = v;
        endcase
        return r;
    endfunction

    state_t      state, state_next;
    logic [27:0] c_reg, d_reg, c_next, d_next;
    logic [3:0]  round_next, round_inc;
    logic        dec_reg, dec_next;
    logic [55:0] cd_load;
    logic [1:0]  load_amt, step_amt;
    logic        unused_parity;

    assign cd_load   = pc1(key_in);
    assign load_amt  = shift_amt(4'd0, decrypt);
    assign round_inc = round + 4'd1;
    assign step_amt  = shift_amt(round_inc, dec_reg);
    assign subkey    = pc2({c_reg, d_reg});

    assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                             key_in[24], key_in[16], key_in[8],  key_in[0]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            c_reg   <= '0;
            d_reg   <= '0;
            round   <= '0;
            dec_reg <= 1'b0;
        end else begin
            state   <= state_next;
            c_reg   <= c_next;
            d_reg   <= d_next;
            round   <= round_next;
            dec_reg <= dec_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        c_next       = c_reg;
        d_next       = d_reg;
        round_next   = round;
        dec_next     = dec_reg;
        subkey_valid = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    c_next     = rot(cd_load[55:28], decrypt, load_amt);
                    d_next     = rot(cd_load[27:0], decrypt, load_amt);
                    dec_next   = decrypt;
                    round_next = 4'd0;
                    state_next = ROUND;
                end
            end
            ROUND: begin
                subkey_valid = 1'b1;
                busy         = 1'b1;
                // Abort wins over a handshake in the same cycle.
                if (abort) begin
                    state_next = IDLE;
                end else if (subkey_ready) begin
                    if (round == 4'd15) begin
                        state_next = DONE;
                    end else begin
                        c_next     = rot(c_reg, dec_reg, step_amt);
                        d_next     = rot(d_reg, dec_reg, step_amt);
                        round_next = round_inc;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/des_key_scheduler.md
DES_KEY_SCHEDULER -- requirements
Module: des_key_scheduler

Interface
REQ-001 SHALL have `clk`, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-002 SHALL have `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have `start`, input, 1 bit: request for a new schedule; sampled only in IDLE.
REQ-004 SHALL have `decrypt`, input, 1 bit: 0 = subkeys in order K1..K16, 1 = K16..K1; sampled with `start`.
REQ-005 SHALL have `key_in`, input, 64 bits: DES key; FIPS bit 1 = `key_in[63]`; parity bits ignored; sampled with `start`.
REQ-006 SHALL have `abort`, input, 1 bit: synchronous cancel of a running schedule.
REQ-007 SHALL have `subkey_ready`, input, 1 bit: round datapath accepts `subkey` this cycle.
REQ-008 SHALL have `subkey`, output, 48 bits: current round subkey; FIPS PC-2 output bit 1 = `subkey[47]`.
REQ-009 SHALL have `subkey_valid`, output, 1 bit: `subkey` is valid.
REQ-010 SHALL have `round`, output, 4 bits: index of the presented subkey, 0..15 = K1..K16, in either direction.
REQ-011 SHALL have `busy`, output, 1 bit: asserted while in ROUND.
REQ-012 SHALL have `done`, output, 1 bit: one-cycle pulse after the last subkey is accepted.

Function
REQ-013 SHALL implement the states IDLE, ROUND and DONE.
REQ-014 SHALL apply the FIPS 46-3 PC-1 table to `key_in`, giving 56-bit C||D with C = bits 1..28 and D = bits 29..56.
REQ-015 SHALL hold C and D as two 28-bit registers and derive `subkey` combinationally from C||D through the FIPS 46-3 PC-2 table.
REQ-016 Encrypt round r (r = 1..16) SHALL rotate C and D left by 1 for r = 1, 2, 9 and 16, and by 2 for all other r.
REQ-017 Decrypt round r SHALL rotate C and D right by 0 for r = 1, by 1 for r = 2, 9 and 16, and by 2 for all other r.
REQ-018 In IDLE with `start`=1, the block SHALL load C||D with PC-1(`key_in`) already rotated by the round-1 amount, latch `decrypt`, set `round`=0 and enter ROUND.
  - The K1 (encrypt) or K16 (decrypt) subkey is therefore valid in the cycle after `start` (latency 1).
REQ-019 In ROUND, `subkey_valid` SHALL be 1, and `subkey` and `round` SHALL hold stable until the handshake `subkey_valid` && `subkey_ready`.
REQ-020 On a handshake with `round` < 15, the block SHALL rotate C and D by the next round's amount and increment `round`.
  - One subkey per cycle SHALL be sustained while `subkey_ready` is held at 1.
REQ-021 On a handshake with `round` = 15, the block SHALL enter DONE.
  - DONE lasts exactly one cycle with `done`=1, `busy`=0 and `subkey_valid`=0; the block then returns to IDLE.
REQ-022 After 16 encrypt rotations, C and D SHALL equal their PC-1 values (28 shifts in total); the bench checks this.
REQ-023 `start` SHALL be ignored in ROUND and in DONE; a new `start` is accepted in the first IDLE cycle after DONE.
REQ-024 `abort`=1 in ROUND SHALL force IDLE on the next edge with no `done` pulse, and SHALL have priority over a simultaneous handshake.
  - `abort` SHALL be ignored in IDLE and in DONE.
REQ-025 Changes on `key_in` or `decrypt` SHALL NOT affect a schedule in progress.
REQ-026 In IDLE, `subkey_valid` and `busy` SHALL be 0, and `subkey` SHALL be don't-care.

Reset
REQ-027 With `rst_n`=0, the block SHALL immediately, without a clock edge, set state = IDLE, C = D = 0, `round` = 0, and `subkey_valid` = `busy` = `done` = 0.
REQ-028 Reset asserted mid-schedule SHALL discard the schedule; after release the block waits in IDLE for `start`.

Verification
REQ-029 Encrypt: `key_in`=0x133457799BBCDFF1, `decrypt`=0, `subkey_ready`=1 -> K1=0x1B02EFFC7072 at `round`=0 one cycle after `start`; K16=0xCB3D8B0E17F5 at `round`=15; `done` pulses 17 cycles after `start`.
REQ-030 Decrypt: same key with `decrypt`=1 -> first subkey 0xCB3D8B0E17F5, last subkey 0x1B02EFFC7072; each subkey equals the encrypt sequence reversed.
REQ-031 Backpressure: `subkey_ready` toggles pseudo-randomly -> `subkey` and `round` stay stable while `subkey_ready`=0; all 16 subkeys appear exactly once and in order.
REQ-032 Abort and ignore: `abort` at `round`=7 -> next cycle IDLE with `busy`=0 and no `done`; `start` pulsed while `busy`=1 -> no effect on the sequence.
REQ-033 Reset and restart: `rst_n` pulsed low at `round`=5 -> all outputs 0 immediately; after release, a new `start` gives the correct K1 one cycle later.
REQ-034 Back-to-back: `start` held high continuously -> a second schedule starts in the cycle after the `done` pulse; C||D returns to PC-1(`key_in`) at the end of each encrypt run.
